// File: rtl/instr_regfile_alu.sv
// instr_regfile_alu: instruction register file with a single-stage signed ALU.
// Each accepted instruction is stored (opcode, operands), executed in one
// register stage and its result written back into the same entry one edge
// later. Reads are registered and write-first.
// Optional macro INSTR_REGFILE_DIV_EN: when defined, DIV/MOD use a signed
// divider; when undefined, no divider is built and DIV/MOD always report
// div_err with a zero result.
module instr_regfile_alu #(
   parameter int OP_WIDTH  = 32,
   parameter int RES_WIDTH = 64,
   parameter int DEPTH     = 32,
   parameter int WP_AUTO   = 0,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        load_en,
   input  logic [AW-1:0]               write_pointer,
   input  logic signed [OP_WIDTH-1:0]  operand_a,
   input  logic signed [OP_WIDTH-1:0]  operand_b,
   input  logic [2:0]                  opcode,
   input  logic [AW-1:0]               read_pointer,
   output logic [2:0]                  rd_opcode,
   output logic signed [OP_WIDTH-1:0]  rd_operand_a,
   output logic signed [OP_WIDTH-1:0]  rd_operand_b,
   output logic signed [RES_WIDTH-1:0] rd_result,
   output logic                        rd_valid,
   output logic                        rd_div_err,
   output logic [AW-1:0]               wr_ptr_q
);

   localparam logic [2:0] OP_ZERO  = 3'd0;
   localparam logic [2:0] OP_PASSA = 3'd1;
   localparam logic [2:0] OP_PASSB = 3'd2;
   localparam logic [2:0] OP_ADD   = 3'd3;
   localparam logic [2:0] OP_SUB   = 3'd4;
   localparam logic [2:0] OP_MULT  = 3'd5;
   localparam logic [2:0] OP_DIV   = 3'd6;
   localparam logic [2:0] OP_MOD   = 3'd7;

   // Sign-extend an operand to the full result width.
   function automatic logic signed [RES_WIDTH-1:0] sext(input logic signed [OP_WIDTH-1:0] v);
      sext = {{(RES_WIDTH-OP_WIDTH){v[OP_WIDTH-1]}}, v};
   endfunction

   // Entry storage
   logic [2:0]                  op_q  [DEPTH];
   logic signed [OP_WIDTH-1:0]  a_q   [DEPTH];
   logic signed [OP_WIDTH-1:0]  b_q   [DEPTH];
   logic signed [RES_WIDTH-1:0] res_q [DEPTH];
   logic [DEPTH-1:0]            vld_q;
   logic [DEPTH-1:0]            err_q;

   // Execute register
   logic                        ex_vld_q;
   logic [AW-1:0]               ex_ptr_q;
   logic [2:0]                  ex_op_q;
   logic signed [OP_WIDTH-1:0]  ex_a_q;
   logic signed [OP_WIDTH-1:0]  ex_b_q;

   logic [AW-1:0]               wr_idx;
   logic                        wb;
   logic signed [RES_WIDTH-1:0] sa;
   logic signed [RES_WIDTH-1:0] sb;
   logic                        b_zero;
   logic signed [RES_WIDTH-1:0] alu_res;
   logic                        alu_err;

   logic [2:0]                  rd_opcode_d;
   logic signed [OP_WIDTH-1:0]  rd_operand_a_d;
   logic signed [OP_WIDTH-1:0]  rd_operand_b_d;
   logic signed [RES_WIDTH-1:0] rd_result_d;
   logic                        rd_valid_d;
   logic                        rd_div_err_d;

   // In auto mode the internal pointer replaces the external index.
   assign wr_idx = (WP_AUTO != 0) ? wr_ptr_q : write_pointer;

   // A newer write to the same entry supersedes the pending write-back.
   assign wb = ex_vld_q && !(load_en && (wr_idx == ex_ptr_q));

   assign sa     = sext(ex_a_q);
   assign sb     = sext(ex_b_q);
   assign b_zero = (ex_b_q == '0);

`ifdef INSTR_REGFILE_DIV_EN
   logic signed [RES_WIDTH-1:0] div_den;
   // Keep the divider away from a zero divisor; the result is overridden anyway.
   assign div_den = b_zero ? RES_WIDTH'(1) : sb;
`endif

   // Execute stage: full-precision signed operation on the captured instruction.
   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (ex_op_q)
         OP_ZERO:  alu_res = '0;
         OP_PASSA: alu_res = sa;
         OP_PASSB: alu_res = sb;
         OP_ADD:   alu_res = sa + sb;
         OP_SUB:   alu_res = sa - sb;
         OP_MULT:  alu_res = sa * sb;
`ifdef INSTR_REGFILE_DIV_EN
         OP_DIV: begin
            alu_err = b_zero;
            alu_res = b_zero ? '0 : (sa / div_den);
         end
         OP_MOD: begin
            alu_err = b_zero;
            alu_res = b_zero ? '0 : (sa % div_den);
         end
`else
         OP_DIV, OP_MOD: begin
            alu_err = 1'b1;
            alu_res = '0;
         end
`endif
         default:  alu_res = '0;
      endcase
   end

   // Write-first read: reflect this edge's capture or write-back on the read entry.
   always_comb begin
      rd_opcode_d    = op_q[read_pointer];
      rd_operand_a_d = a_q[read_pointer];
      rd_operand_b_d = b_q[read_pointer];
      rd_result_d    = res_q[read_pointer];
      rd_valid_d     = vld_q[read_pointer];
      rd_div_err_d   = err_q[read_pointer];
      if (load_en && (wr_idx == read_pointer)) begin
         rd_opcode_d    = opcode;
         rd_operand_a_d = operand_a;
         rd_operand_b_d = operand_b;
         rd_valid_d     = 1'b0;
         rd_div_err_d   = 1'b0;
      end
      if (wb && (ex_ptr_q == read_pointer)) begin
         rd_result_d  = alu_res;
         rd_valid_d   = 1'b1;
         rd_div_err_d = alu_err;
      end
   end

   // Entry storage: capture of new instructions and result write-back.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]  <= '0;
            a_q[i]   <= '0;
            b_q[i]   <= '0;
            res_q[i] <= '0;
         end
         vld_q <= '0;
         err_q <= '0;
      end else begin
         if (wb) begin
            res_q[ex_ptr_q] <= alu_res;
            err_q[ex_ptr_q] <= alu_err;
            vld_q[ex_ptr_q] <= 1'b1;
         end
         if (load_en) begin
            op_q[wr_idx]  <= opcode;
            a_q[wr_idx]   <= operand_a;
            b_q[wr_idx]   <= operand_b;
            vld_q[wr_idx] <= 1'b0;
            err_q[wr_idx] <= 1'b0;
         end
      end
   end

   // Execute register: one instruction in flight between capture and write-back.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ex_vld_q <= 1'b0;
         ex_ptr_q <= '0;
         ex_op_q  <= '0;
         ex_a_q   <= '0;
         ex_b_q   <= '0;
      end else begin
         ex_vld_q <= load_en;
         if (load_en) begin
            ex_ptr_q <= wr_idx;
            ex_op_q  <= opcode;
            ex_a_q   <= operand_a;
            ex_b_q   <= operand_b;
         end
      end
   end

   // Auto-increment write pointer; wraps naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
      end else if ((WP_AUTO != 0) && load_en) begin
         wr_ptr_q <= wr_ptr_q + AW'(1);
      end
   end

   // Registered read port.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_opcode    <= '0;
         rd_operand_a <= '0;
         rd_operand_b <= '0;
         rd_result    <= '0;
         rd_valid     <= 1'b0;
         rd_div_err   <= 1'b0;
      end else begin
         rd_opcode    <= rd_opcode_d;
         rd_operand_a <= rd_operand_a_d;
         rd_operand_b <= rd_operand_b_d;
         rd_result    <= rd_result_d;
         rd_valid     <= rd_valid_d;
         rd_div_err   <= rd_div_err_d;
      end
   end

endmodule

// File: tb/tb_instr_regfile_alu.sv
// tb_instr_regfile_alu: directed bench for instr_regfile_alu.
// Instance u_dut uses default parameters; u_auto uses WP_AUTO=1, DEPTH=4.
// Inputs are driven on the falling edge and outputs sampled on the falling edge.
module tb_instr_regfile_alu;

   localparam logic [2:0] OP_ZERO  = 3'd0;
   localparam logic [2:0] OP_PASSA = 3'd1;
   localparam logic [2:0] OP_PASSB = 3'd2;
   localparam logic [2:0] OP_ADD   = 3'd3;
   localparam logic [2:0] OP_SUB   = 3'd4;
   localparam logic [2:0] OP_MULT  = 3'd5;
   localparam logic [2:0] OP_DIV   = 3'd6;
   localparam logic [2:0] OP_MOD   = 3'd7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default instance signals
   logic               reset_n;
   logic               load_en;
   logic [4:0]         write_pointer;
   logic signed [31:0] operand_a;
   logic signed [31:0] operand_b;
   logic [2:0]         opcode;
   logic [4:0]         read_pointer;
   logic [2:0]         rd_opcode;
   logic signed [31:0] rd_operand_a;
   logic signed [31:0] rd_operand_b;
   logic signed [63:0] rd_result;
   logic               rd_valid;
   logic               rd_div_err;
   logic [4:0]         wr_ptr_q;

   // Auto-pointer instance signals
   logic               a_reset_n;
   logic               a_load_en;
   logic [1:0]         a_write_pointer;
   logic signed [31:0] a_operand_a;
   logic signed [31:0] a_operand_b;
   logic [2:0]         a_opcode;
   logic [1:0]         a_read_pointer;
   logic [2:0]         a_rd_opcode;
   logic signed [31:0] a_rd_operand_a;
   logic signed [31:0] a_rd_operand_b;
   logic signed [63:0] a_rd_result;
   logic               a_rd_valid;
   logic               a_rd_div_err;
   logic [1:0]         a_wr_ptr_q;

   int n_chk  = 0;
   int n_pass = 0;

   instr_regfile_alu u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .load_en       (load_en),
      .write_pointer (write_pointer),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .opcode        (opcode),
      .read_pointer  (read_pointer),
      .rd_opcode     (rd_opcode),
      .rd_operand_a  (rd_operand_a),
      .rd_operand_b  (rd_operand_b),
      .rd_result     (rd_result),
      .rd_valid      (rd_valid),
      .rd_div_err    (rd_div_err),
      .wr_ptr_q      (wr_ptr_q)
   );

   instr_regfile_alu #(.OP_WIDTH(32), .RES_WIDTH(64), .DEPTH(4), .WP_AUTO(1)) u_auto (
      .clk           (clk),
      .reset_n       (a_reset_n),
      .load_en       (a_load_en),
      .write_pointer (a_write_pointer),
      .operand_a     (a_operand_a),
      .operand_b     (a_operand_b),
      .opcode        (a_opcode),
      .read_pointer  (a_read_pointer),
      .rd_opcode     (a_rd_opcode),
      .rd_operand_a  (a_rd_operand_a),
      .rd_operand_b  (a_rd_operand_b),
      .rd_result     (a_rd_result),
      .rd_valid      (a_rd_valid),
      .rd_div_err    (a_rd_div_err),
      .wr_ptr_q      (a_wr_ptr_q)
   );

   // Issue one instruction on the default instance and read it back; returns
   // at the falling edge after the write-back edge.
   task automatic issue(input logic [4:0] ptr, input logic [2:0] op,
                        input logic signed [31:0] a, input logic signed [31:0] b);
      @(negedge clk);
      load_en       = 1'b1;
      write_pointer = ptr;
      opcode        = op;
      operand_a     = a;
      operand_b     = b;
      read_pointer  = ptr;
      @(negedge clk);
      load_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b0;  a_reset_n = 1'b0;
      load_en = 1'b1;  write_pointer = 5'd0; opcode = OP_ADD; operand_a = 1; operand_b = 1;
      a_load_en = 1'b1; a_opcode = OP_PASSA; a_operand_a = 5;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;  a_reset_n = 1'b1;
      load_en = 1'b0;  a_load_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         read_pointer = 5'(i);
         @(negedge clk);
         n_chk++;
         if ({rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_valid, rd_div_err} !== '0) begin
            $display("FAIL reset_entry%0d: op=%0d a=%0d b=%0d res=%0d vld=%0b err=%0b, want all 0",
                     i, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_valid, rd_div_err);
         end else n_pass++;
      end
      n_chk++;
      if (wr_ptr_q !== 5'd0) $display("FAIL reset_wr_ptr: got %0d want 0", wr_ptr_q);
      else n_pass++;
      n_chk++;
      if (a_wr_ptr_q !== 2'd0) $display("FAIL reset_auto_wr_ptr: got %0d want 0", a_wr_ptr_q);
      else n_pass++;
   endtask

   task automatic test_write_read();
      @(negedge clk);
      load_en = 1'b1; write_pointer = 5'd3; opcode = OP_ADD;
      operand_a = -15; operand_b = 7; read_pointer = 5'd3;
      @(negedge clk);
      load_en = 1'b0;
      n_chk++;
      if (rd_valid !== 1'b0) $display("FAIL wr_valid_early: got %0b want 0", rd_valid);
      else n_pass++;
      n_chk++;
      if ({rd_opcode, rd_operand_a, rd_operand_b} !== {OP_ADD, -32'sd15, 32'sd7})
         $display("FAIL wr_fields: op=%0d a=%0d b=%0d want 3 -15 7", rd_opcode, rd_operand_a, rd_operand_b);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if ({rd_valid, rd_div_err} !== 2'b10) $display("FAIL wr_valid: vld=%0b err=%0b want 1 0", rd_valid, rd_div_err);
      else n_pass++;
      n_chk++;
      if (rd_result !== -64'sd8) $display("FAIL wr_add_result: got %0d want -8", rd_result);
      else n_pass++;
   endtask

   task automatic test_mult_sub();
      @(negedge clk);
      load_en = 1'b1; write_pointer = 5'd5; opcode = OP_MULT;
      operand_a = -32768; operand_b = 32767; read_pointer = 5'd5;
      @(negedge clk);
      write_pointer = 5'd6; opcode = OP_SUB;
      operand_a = 32'sh80000000; operand_b = 1;
      @(negedge clk);
      load_en = 1'b0;
      n_chk++;
      if ({rd_valid, rd_result} !== {1'b1, -64'sd1073709056})
         $display("FAIL mult_result: vld=%0b res=%0d want 1 -1073709056", rd_valid, rd_result);
      else n_pass++;
      read_pointer = 5'd6;
      @(negedge clk);
      n_chk++;
      if ({rd_valid, rd_result} !== {1'b1, 64'shFFFFFFFF7FFFFFFF})
         $display("FAIL sub_result: vld=%0b res=%0d want 1 -2147483649", rd_valid, rd_result);
      else n_pass++;
   endtask

   task automatic test_divide();
      logic signed [63:0] e_res;
      logic               e_err;
`ifdef INSTR_REGFILE_DIV_EN
      e_res = -64'sd3; e_err = 1'b0;
`else
      e_res = 64'sd0;  e_err = 1'b1;
`endif
      issue(5'd7, OP_DIV, -7, 2);
      n_chk++;
      if ({rd_valid, rd_div_err, rd_result} !== {1'b1, e_err, e_res})
         $display("FAIL div_neg: vld=%0b err=%0b res=%0d want 1 %0b %0d", rd_valid, rd_div_err, rd_result, e_err, e_res);
      else n_pass++;
`ifdef INSTR_REGFILE_DIV_EN
      e_res = -64'sd1;
`endif
      issue(5'd7, OP_MOD, -7, 2);
      n_chk++;
      if ({rd_valid, rd_div_err, rd_result} !== {1'b1, e_err, e_res})
         $display("FAIL mod_neg: vld=%0b err=%0b res=%0d want 1 %0b %0d", rd_valid, rd_div_err, rd_result, e_err, e_res);
      else n_pass++;
      issue(5'd7, OP_DIV, 9, 0);
      n_chk++;
      if ({rd_valid, rd_div_err, rd_result} !== {1'b1, 1'b1, 64'sd0})
         $display("FAIL div_zero: vld=%0b err=%0b res=%0d want 1 1 0", rd_valid, rd_div_err, rd_result);
      else n_pass++;
`ifdef INSTR_REGFILE_DIV_EN
      e_res = 64'sd3;
`endif
      issue(5'd7, OP_DIV, 9, 3);
      n_chk++;
      if ({rd_valid, rd_div_err, rd_result} !== {1'b1, e_err, e_res})
         $display("FAIL div_pos: vld=%0b err=%0b res=%0d want 1 %0b %0d", rd_valid, rd_div_err, rd_result, e_err, e_res);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      load_en = 1'b1; write_pointer = 5'd2; opcode = OP_PASSA;
      operand_a = 4; operand_b = 0; read_pointer = 5'd2;
      @(negedge clk);
      opcode = OP_PASSB; operand_a = 0; operand_b = 9;
      n_chk++;
      if ({rd_valid, rd_result, rd_operand_a} !== {1'b0, 64'sd0, 32'sd4})
         $display("FAIL b2b_first: vld=%0b res=%0d a=%0d want 0 0 4", rd_valid, rd_result, rd_operand_a);
      else n_pass++;
      @(negedge clk);
      load_en = 1'b0;
      n_chk++;
      if ({rd_valid, rd_result, rd_opcode, rd_operand_b} !== {1'b0, 64'sd0, OP_PASSB, 32'sd9})
         $display("FAIL b2b_second: vld=%0b res=%0d op=%0d b=%0d want 0 0 2 9", rd_valid, rd_result, rd_opcode, rd_operand_b);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if ({rd_valid, rd_result} !== {1'b1, 64'sd9})
         $display("FAIL b2b_final: vld=%0b res=%0d want 1 9", rd_valid, rd_result);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if ({rd_valid, rd_result} !== {1'b1, 64'sd9})
         $display("FAIL b2b_hold: vld=%0b res=%0d want 1 9", rd_valid, rd_result);
      else n_pass++;
   endtask

   task automatic test_auto();
      logic [1:0] e_ptr;
      a_write_pointer = 2'd3;
      a_read_pointer  = 2'd0;
      a_opcode        = OP_PASSA;
      a_operand_b     = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         a_load_en   = 1'b1;
         a_operand_a = 32'(10 + k);
         @(negedge clk);
         a_load_en = 1'b0;
         e_ptr = 2'((k + 1) % 4);
         n_chk++;
         if (a_wr_ptr_q !== e_ptr) $display("FAIL auto_ptr%0d: got %0d want %0d", k, a_wr_ptr_q, e_ptr);
         else n_pass++;
      end
      @(negedge clk);
      n_chk++;
      if ({a_rd_valid, a_rd_result, a_rd_operand_a, a_rd_opcode} !== {1'b1, 64'sd14, 32'sd14, OP_PASSA})
         $display("FAIL auto_entry0: vld=%0b res=%0d a=%0d op=%0d want 1 14 14 1",
                  a_rd_valid, a_rd_result, a_rd_operand_a, a_rd_opcode);
      else n_pass++;
      // Write entry 1, then reset on the write-back edge.
      @(negedge clk);
      a_load_en = 1'b1; a_operand_a = 77; a_read_pointer = 2'd1;
      @(negedge clk);
      a_load_en = 1'b0; a_reset_n = 1'b0;
      n_chk++;
      if (a_wr_ptr_q !== 2'd2) $display("FAIL auto_ptr_pre_reset: got %0d want 2", a_wr_ptr_q);
      else n_pass++;
      @(negedge clk);
      a_reset_n = 1'b1;
      n_chk++;
      if (a_wr_ptr_q !== 2'd0) $display("FAIL auto_ptr_reset: got %0d want 0", a_wr_ptr_q);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if ({a_rd_valid, a_rd_result, a_rd_operand_a, a_rd_opcode} !== '0)
         $display("FAIL auto_reset_entry1: vld=%0b res=%0d a=%0d op=%0d want all 0",
                  a_rd_valid, a_rd_result, a_rd_operand_a, a_rd_opcode);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if ({a_rd_valid, a_rd_result} !== '0)
         $display("FAIL auto_reset_hold: vld=%0b res=%0d want 0 0", a_rd_valid, a_rd_result);
      else n_pass++;
   endtask

   initial begin
      reset_n = 1'b0; load_en = 1'b0; write_pointer = '0; operand_a = '0;
      operand_b = '0; opcode = OP_ZERO; read_pointer = '0;
      a_reset_n = 1'b0; a_load_en = 1'b0; a_write_pointer = '0; a_operand_a = '0;
      a_operand_b = '0; a_opcode = OP_ZERO; a_read_pointer = '0;
      test_reset();
      test_write_read();
      test_mult_sub();
      test_divide();
      test_back_to_back();
      test_auto();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
